reset_sequencer: RTL

Parametrised reset-generation block that sits between the board-level reset input and the system bus and its attached masters and slaves. It asserts reset immediately and asynchronously, and synchronises its release through a configurable flop chain. It holds all domains in reset for a minimum time, then releases NUM_DOMAINS reset outputs one at a time in a fixed order with a programmable gap. It also supports a synchronous software-requested reset and reports completion and reset cause.

---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_sync.sv | 31 +++
 rtl/reset_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its synchroniser.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam logic CAUSE_HW = 1'b0;
  localparam logic CAUSE_SW = 1'b1;

  // Counter width for a count of n states; never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-release reset chain with an active-low output.
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_o,
  output logic rst_n_early_o
);

  logic [STAGES-1:0] chain_d;
  logic [STAGES-1:0] chain_q;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign rst_n_o = chain_q[STAGES-1];
  // Penultimate tap: high exactly one edge before rst_n_o rises, so a consumer
  // can change state on the same edge that the synchronised release appears.
  assign rst_n_early_o = chain_q[STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// Holds all domains in reset for a minimum time after synchronised release, then
// releases them one by one with a fixed gap; supports a software-requested reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned MIN_HOLD    = 4,
  parameter int unsigned RELEASE_GAP = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   rst_done,
  output logic                   rst_cause,
  output logic [CNT_W-1:0]       soft_rst_cnt,
  output logic [1:0]             seq_state
);

  localparam int unsigned HOLD_W = cnt_width(MIN_HOLD);
  localparam int unsigned GAP_W  = cnt_width(RELEASE_GAP);
  localparam int unsigned DOM_W  = cnt_width(NUM_DOMAINS);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
  localparam logic [DOM_W-1:0]  DOM_LAST  = DOM_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic sync_n;
  logic sync_early;
  logic sync_go;

  seq_state_e             state_d, state_q;
  logic [HOLD_W-1:0]      hold_d, hold_q;
  logic [GAP_W-1:0]       gap_d, gap_q;
  logic [DOM_W-1:0]       dom_d, dom_q;
  logic [NUM_DOMAINS-1:0] rst_d, rst_q;
  logic                   done_d, done_q;
  logic                   cause_d, cause_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;

  reset_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst_n        (reset),
    .rst_n_o      (sync_n),
    .rst_n_early_o(sync_early)
  );

  assign sync_go = sync_early | sync_n;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    dom_d   = dom_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    // A software request outranks any release due on the same edge.
    if ((state_q != ST_RESET) && sw_rst_req) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      gap_d   = '0;
      dom_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
      cause_d = CAUSE_SW;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      case (state_q)
        ST_RESET: begin
          if (sync_go) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            state_d = ST_RESET;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rst_d = NUM_DOMAINS'(1'b1);
            gap_d = '0;
            dom_d = DOM_W'(1);
            if (NUM_DOMAINS == 1) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            rst_d = NUM_DOMAINS'({rst_q, 1'b1});
            gap_d = '0;
            if (dom_q == DOM_LAST) begin
              dom_d   = '0;
              done_d  = 1'b1;
              state_d = ST_RUN;
            end else begin
              dom_d = dom_q + DOM_W'(1);
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
      hold_q  <= '0;
      gap_q   <= '0;
      dom_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_HW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      dom_q   <= dom_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rst_n_out    = rst_q;
  assign rst_done     = done_q;
  assign rst_cause    = cause_q;
  assign soft_rst_cnt = cnt_q;
  assign seq_state    = state_q;

endmodule
